io_timer: RTL and testbench
===========================

Name: io_timer

Overview:
- Memory-mapped down-counting timer peripheral on the IO bus, at IO slot 0xf4000000.
- The hub decodes addr[27:24] and qualifies `we`. The hub's readback mux selects `dataout` for that slot.
- Provides a prescaled tick, one-shot or auto-reload countdown, a sticky expiry flag and a level interrupt to the CPU.
- Register offsets are taken from addr[7:0]; word aligned.

Parameters:
- WIDTH, 32, counter and LOAD register width (1..32); register reads zero-extend to 32 bits.
- PWIDTH, 16, prescaler width (1..32).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous reset, active-high.
- addr  input  8  register offset; bits [4:2] select the register, bits [1:0] are ignored.
- datain  input  32  write data from the CPU.
- we  input  1  write strobe, already qualified by the hub for this slot.
- dataout  output  32  combinational read data for the current addr.
- irq  output  1  level interrupt = status.expired & ctrl.ie.

Behaviour:
- Register map (addr[4:2]); any other offset reads 0 and ignores writes:
  - 0 CTRL (R/W): bit0 en, bit1 auto, bit2 ie, bit3 start (write-only; reads 0).
  - 1 LOAD (R/W): WIDTH bits.
  - 2 COUNT (R/W): current count; a write loads it directly.
  - 3 STATUS: bit0 expired. Write 1 to clear; writing 0 has no effect.
  - 4 PRESCALE (R/W): PWIDTH bits.
- Reset (synchronous, reset=1 at a clk edge):
  - en=auto=ie=0, LOAD=0, COUNT=0, PRESCALE=0, prescale counter pc=0, expired=0.
  - Result: irq=0 and dataout for every register reads 0. Reset overrides any same-cycle write.
  - Reset mid-count: the timer stops; no expiry is raised on that edge.
- Prescaler:
  - When en=1, pc increments each cycle. When pc==PRESCALE, pc wraps to 0 and a tick is generated that cycle.
  - When en=0, pc holds.
  - PRESCALE=0 gives a tick every cycle.
- On a tick:
  - If COUNT!=0: COUNT <= COUNT-1.
  - If COUNT==0: expired <= 1. If auto=1, COUNT <= LOAD; else en <= 0 and COUNT stays 0.
  - Period from start to expiry = (LOAD+1)*(PRESCALE+1) cycles; the expired flag is visible on the following cycle.
- Start: a CTRL write with bit3=1 sets COUNT <= LOAD and pc <= 0 in the same edge, and applies the en/auto/ie bits of that write.
- Bus-write priority over internal updates in the same cycle:
  - COUNT write beats the tick decrement/reload.
  - CTRL write beats the one-shot auto-clear of en.
  - PRESCALE write also clears pc.
- STATUS: a hardware expiry set in the same cycle as a W1C clear wins, so expired stays 1.
- No arithmetic wrap: COUNT never decrements below 0.
- Reads have zero latency: dataout is combinational from addr and current register state.
- irq is registered-state derived, so it is glitch-free relative to clk.

Test Plan:
- Reset, then read all offsets 0x00–0x10 -> each reads 0x00000000; irq=0.
- One-shot: write PRESCALE=0, LOAD=4, CTRL=0x0D (en, ie, start). Expected response:
  - expired=1 and irq=1 exactly 5 cycles after the write edge.
  - COUNT reads 0 and CTRL.en reads 0 afterwards; expired stays 1 with no further activity.
- Auto-reload with prescale: PRESCALE=2, LOAD=1, CTRL=0x0B. Expected response:
  - expired first sets after 6 cycles.
  - After a W1C clear, it sets again every 6 cycles; COUNT sequence per tick is 1,0,1,0.
- Collision: drive a STATUS write of 1 in the same cycle as the expiry tick -> expired remains 1.
  - A COUNT write of 0x10 on a tick cycle -> COUNT reads 0x10 the next cycle, not decremented.
- Disable/hold: with the timer running, write CTRL=0x00 -> COUNT and pc freeze for 20 cycles.
  - Re-enabling with CTRL=0x01 resumes from the frozen values.
- Reset mid-count: assert reset for 1 cycle at COUNT=3 -> all registers read 0 next cycle; no expiry, irq=0. Also:
  - Write 0xFFFFFFFF to offset 0x14 -> ignored; reads 0.
  - With WIDTH=8, LOAD=0x1FF write reads back 0x000000FF.

Source files
------------

// File: rtl/io_timer.sv
// io_timer: memory-mapped down-counting timer for the IO hub.
// Prescaled tick, one-shot or auto-reload countdown, sticky expiry and irq.
module io_timer #(
  parameter int WIDTH  = 32,
  parameter int PWIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  addr,
  input  logic [31:0] datain,
  input  logic        we,
  output logic [31:0] dataout,
  output logic        irq
);

  logic              en;
  logic              auto_rl;
  logic              ie;
  logic              expired;
  logic [WIDTH-1:0]  load_q;
  logic [WIDTH-1:0]  count_q;
  logic [PWIDTH-1:0] pre_q;
  logic [PWIDTH-1:0] pc_q;

  logic       hit;
  logic [2:0] sel;
  logic       s_ctrl, s_load, s_count, s_stat, s_pre;
  logic       w_ctrl, w_load, w_count, w_stat, w_pre;
  logic       start;
  logic       tick;
  logic       zero;
  logic       expire;
  logic       unused;

  assign hit     = (addr[7:5] == 3'd0);
  assign sel     = addr[4:2];
  assign s_ctrl  = hit && (sel == 3'd0);
  assign s_load  = hit && (sel == 3'd1);
  assign s_count = hit && (sel == 3'd2);
  assign s_stat  = hit && (sel == 3'd3);
  assign s_pre   = hit && (sel == 3'd4);

  assign w_ctrl  = we && s_ctrl;
  assign w_load  = we && s_load;
  assign w_count = we && s_count;
  assign w_stat  = we && s_stat;
  assign w_pre   = we && s_pre;
  assign start   = w_ctrl && datain[3];

  assign tick    = en && (pc_q == pre_q);
  assign zero    = (count_q == '0);
  assign expire  = tick && zero;

  assign irq     = expired && ie;
  assign unused  = ^{addr[1:0], datain};

  always_ff @(posedge clk) begin
    if (reset) begin
      en      <= 1'b0;
      auto_rl <= 1'b0;
      ie      <= 1'b0;
      expired <= 1'b0;
      load_q  <= '0;
      count_q <= '0;
      pre_q   <= '0;
      pc_q    <= '0;
    end else begin
      if (w_ctrl) begin
        en      <= datain[0];
        auto_rl <= datain[1];
        ie      <= datain[2];
      end else if (expire && !auto_rl) begin
        en <= 1'b0;
      end

      if (w_load)
        load_q <= datain[WIDTH-1:0];

      if (w_pre)
        pre_q <= datain[PWIDTH-1:0];

      if (w_pre || start)
        pc_q <= '0;
      else if (tick)
        pc_q <= '0;
      else if (en)
        pc_q <= pc_q + PWIDTH'(1);

      // bus writes outrank the tick's decrement/reload
      if (w_count)
        count_q <= datain[WIDTH-1:0];
      else if (start)
        count_q <= load_q;
      else if (tick && !zero)
        count_q <= count_q - WIDTH'(1);
      else if (expire && auto_rl)
        count_q <= load_q;

      // a same-edge expiry wins over the W1C clear
      if (expire)
        expired <= 1'b1;
      else if (w_stat && datain[0])
        expired <= 1'b0;
    end
  end

  always_comb begin
    dataout = '0;
    unique case (1'b1)
      s_ctrl:  dataout[2:0] = {ie, auto_rl, en};
      s_load:  dataout[WIDTH-1:0] = load_q;
      s_count: dataout[WIDTH-1:0] = count_q;
      s_stat:  dataout[0] = expired;
      s_pre:   dataout[PWIDTH-1:0] = pre_q;
      default: dataout = '0;
    endcase
  end

endmodule

// File: tb/tb_io_timer.sv
// tb_io_timer: directed bench for io_timer with a rule-level model
// checked every cycle plus literal spot checks.
module tb_io_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  addr = 8'h00;
  logic [31:0] datain = 32'h0;
  logic        we = 1'b0;
  logic [31:0] dataout;
  logic        irq;
  logic [31:0] d8;
  logic        irq8;

  int vectors = 0;
  int miscompares = 0;
  bit started = 1'b0;

  io_timer #(.WIDTH(32), .PWIDTH(16)) dut (
    .clk(clk), .reset(reset), .addr(addr), .datain(datain),
    .we(we), .dataout(dataout), .irq(irq)
  );

  io_timer #(.WIDTH(8), .PWIDTH(16)) dut8 (
    .clk(clk), .reset(reset), .addr(addr), .datain(datain),
    .we(we), .dataout(d8), .irq(irq8)
  );

  always #5 clk = ~clk;

  // model state
  logic        m_en, m_auto, m_ie, m_exp;
  logic [31:0] m_load, m_count;
  logic [15:0] m_pre, m_pc;

  always @(posedge clk) begin : model
    logic        tk;
    logic [31:0] nc, nl;
    logic [15:0] npc, npr;
    logic        ne, na, ni, nx;
    if (reset) begin
      m_en = 0; m_auto = 0; m_ie = 0; m_exp = 0;
      m_load = 0; m_count = 0; m_pre = 0; m_pc = 0;
    end else begin
      tk = m_en && (m_pc == m_pre);
      nc = m_count; nl = m_load; npc = m_pc; npr = m_pre;
      ne = m_en; na = m_auto; ni = m_ie; nx = m_exp;
      if (m_en) npc = tk ? 16'd0 : m_pc + 16'd1;
      if (we && addr == 8'h0C && datain[0]) nx = 0;
      if (tk) begin
        if (m_count != 0) nc = m_count - 1;
        else begin
          nx = 1;
          if (m_auto) nc = m_load;
          else ne = 0;
        end
      end
      if (we) begin
        case (addr)
          8'h00: begin
            ne = datain[0]; na = datain[1]; ni = datain[2];
            if (datain[3]) begin nc = m_load; npc = 0; end
          end
          8'h04: nl = datain;
          8'h08: nc = datain;
          8'h10: begin npr = datain[15:0]; npc = 0; end
          default: ;
        endcase
      end
      m_count = nc; m_load = nl; m_pc = npc; m_pre = npr;
      m_en = ne; m_auto = na; m_ie = ni; m_exp = nx;
    end
    started = 1'b1;
  end

  function automatic logic [31:0] m_read(input logic [7:0] a);
    if (a[7:5] != 3'd0) return 32'h0;
    case (a[4:2])
      3'd0: return {29'h0, m_ie, m_auto, m_en};
      3'd1: return m_load;
      3'd2: return m_count;
      3'd3: return {31'h0, m_exp};
      3'd4: return {16'h0, m_pre};
      default: return 32'h0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (started) begin
      vectors++;
      if (dataout !== m_read(addr) || irq !== (m_exp & m_ie)) begin
        miscompares++;
        $display("FAIL model addr=%h dataout=%h irq=%b expected %h irq=%b",
                 addr, dataout, irq, m_read(addr), m_exp & m_ie);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    addr = a; datain = d; we = 1'b1;
    cyc();
    we = 1'b0; datain = 32'h0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic rd(input string nm, input logic [7:0] a,
                    input logic [31:0] exp);
    addr = a;
    #1;
    chk(nm, dataout, exp);
  endtask

  logic [31:0] cnt_tab [12] = '{1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1};
  logic        exp_tab [12] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};

  initial begin
    cyc(); cyc();
    reset = 1'b0;

    for (int i = 0; i < 5; i++)
      rd("reset_read", 8'(i * 4), 32'h0);
    chk("reset_irq", {31'h0, irq}, 32'h0);

    // one-shot
    wr(8'h10, 0);
    wr(8'h04, 4);
    wr(8'h00, 32'h0D);
    for (int k = 1; k <= 5; k++) begin
      if (k < 5) begin
        rd("oneshot_pending", 8'h0C, 32'h0);
        cyc();
      end else begin
        rd("oneshot_expired", 8'h0C, 32'h1);
        chk("oneshot_irq", {31'h0, irq}, 32'h1);
      end
      if (k == 4) cyc();
    end
    rd("oneshot_count", 8'h08, 32'h0);
    rd("oneshot_ctrl", 8'h00, 32'h4);
    repeat (5) cyc();
    rd("oneshot_sticky", 8'h0C, 32'h1);
    wr(8'h0C, 1);
    rd("w1c_clear", 8'h0C, 32'h0);
    chk("w1c_irq", {31'h0, irq}, 32'h0);

    // auto-reload, prescale 2
    wr(8'h10, 2);
    wr(8'h04, 1);
    wr(8'h00, 32'h0B);
    for (int k = 0; k < 12; k++) begin
      if (k == 6) begin
        addr = 8'h0C; datain = 1; we = 1'b1;
      end
      cyc();
      we = 1'b0; datain = 0;
      rd("auto_count", 8'h08, cnt_tab[k]);
      rd("auto_expired", 8'h0C, {31'h0, exp_tab[k]});
    end

    // collision: W1C on expiry edge
    wr(8'h0C, 1);
    wr(8'h00, 32'h0B);
    repeat (5) cyc();
    rd("coll_pre", 8'h0C, 32'h0);
    wr(8'h0C, 1);
    rd("coll_status", 8'h0C, 32'h1);
    cyc(); cyc();
    wr(8'h08, 32'h10);
    rd("coll_count", 8'h08, 32'h10);

    // disable/hold
    wr(8'h00, 32'h00);
    for (int k = 0; k < 20; k++) begin
      cyc();
      rd("hold_count", 8'h08, 32'h10);
    end
    wr(8'h00, 32'h01);
    cyc();
    rd("resume_r1", 8'h08, 32'h10);
    cyc();
    rd("resume_r2", 8'h08, 32'h0F);

    // reset mid-count
    wr(8'h00, 32'h05);
    wr(8'h08, 3);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 5; i++)
      rd("midrst_read", 8'(i * 4), 32'h0);
    chk("midrst_irq", {31'h0, irq}, 32'h0);
    repeat (10) cyc();
    rd("midrst_noexp", 8'h0C, 32'h0);

    // unmapped offset and narrow width
    wr(8'h14, 32'hFFFF_FFFF);
    rd("unmapped", 8'h14, 32'h0);
    rd("unmapped_ctrl", 8'h00, 32'h0);
    wr(8'h04, 32'h1FF);
    addr = 8'h04;
    #1;
    chk("w8_load", d8, 32'h0000_00FF);
    chk("w32_load", dataout, 32'h0000_01FF);
    chk("w8_irq", {31'h0, irq8}, 32'h0);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
